// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving NUM_BUSES registered common data buses from NUM_REQ units.
// Define CDB_ARB_STARVE_GUARD_EN to compile in the per-unit anti-starvation wait counters.
module cdb_arbiter #(
  parameter int NUM_REQ      = 5,
  parameter int NUM_BUSES    = 2,
  parameter int DATA_W       = 64,
  parameter int SRC_W        = $clog2(NUM_REQ),
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_flush,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_grant,
  output logic [NUM_BUSES-1:0]        o_cdb_valid,
  output logic [NUM_BUSES*DATA_W-1:0] o_cdb_data,
  output logic [NUM_BUSES*SRC_W-1:0]  o_cdb_src
);

  logic [SRC_W-1:0]            r_rr_ptr;
  logic [NUM_BUSES-1:0]        r_cdb_valid;
  logic [NUM_BUSES*DATA_W-1:0] r_cdb_data;
  logic [NUM_BUSES*SRC_W-1:0]  r_cdb_src;

  logic [NUM_REQ-1:0]   w_eligible;
  logic [NUM_REQ-1:0]   w_grant;
  logic [NUM_BUSES-1:0] w_bus_valid;
  logic [SRC_W-1:0]     w_bus_src  [NUM_BUSES];
  logic [DATA_W-1:0]    w_bus_data [NUM_BUSES];
  logic [SRC_W-1:0]     w_next_ptr;

  assign w_eligible = i_req_valid & ~{NUM_REQ{i_flush | reset}};

`ifdef CDB_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_wait_cnt [NUM_REQ];
`endif

  // Winners take buses in the order found: starving units first (guard build), then the circular scan.
  always_comb begin
    int won;
    int idx;
    won        = 0;
    idx        = 0;
    w_grant    = '0;
    w_bus_valid = '0;
    w_next_ptr = r_rr_ptr;
    for (int k = 0; k < NUM_BUSES; k++) begin
      w_bus_src[k] = '0;
    end
`ifdef CDB_ARB_STARVE_GUARD_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_eligible[i] && r_wait_cnt[i] == CNT_W'(STARVE_LIMIT) && won < NUM_BUSES) begin
        w_grant[i] = 1'b1;
        for (int k = 0; k < NUM_BUSES; k++) begin
          if (k == won) begin
            w_bus_valid[k] = 1'b1;
            w_bus_src[k]   = SRC_W'(i);
          end
        end
        won = won + 1;
      end
    end
`endif
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = int'(r_rr_ptr) + j;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (w_eligible[idx] && !w_grant[idx] && won < NUM_BUSES) begin
        w_grant[idx] = 1'b1;
        for (int k = 0; k < NUM_BUSES; k++) begin
          if (k == won) begin
            w_bus_valid[k] = 1'b1;
            w_bus_src[k]   = SRC_W'(idx);
          end
        end
        w_next_ptr = (idx == NUM_REQ - 1) ? '0 : SRC_W'(idx + 1);
        won = won + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_BUSES; k++) begin
      w_bus_data[k] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_bus_valid[k] && w_bus_src[k] == SRC_W'(i)) begin
          w_bus_data[k] = i_req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else begin
      r_rr_ptr    <= w_next_ptr;
      r_cdb_valid <= w_bus_valid;
      for (int k = 0; k < NUM_BUSES; k++) begin
        r_cdb_data[k*DATA_W +: DATA_W] <= w_bus_data[k];
        r_cdb_src[k*SRC_W +: SRC_W]    <= w_bus_src[k];
      end
    end
  end

`ifdef CDB_ARB_STARVE_GUARD_EN
  // Counts saturate at STARVE_LIMIT; a flush forgets all accumulated waiting.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      for (int i = 0; i < NUM_REQ; i++) r_wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!i_req_valid[i] || w_grant[i]) begin
          r_wait_cnt[i] <= '0;
        end else if (r_wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
          r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
        end
      end
    end
  end
`endif

  assign o_req_grant = w_grant;
  assign o_cdb_valid = r_cdb_valid;
  assign o_cdb_data  = r_cdb_data;
  assign o_cdb_src   = r_cdb_src;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised arbiter and driver for the common data buses (CDBs). NUM_REQ execution units (ROB, ALU, mult/div, load/store, branch, …) compete each cycle for NUM_BUSES result broadcast channels. It replaces the fixed two-bus scheme with per-unit addresses. Grants are round-robin, bus outputs are registered, and flush is supported. An optional anti-starvation guard can be compiled in.

## Interface
- NUM_REQ, 5, number of requesting units; must be at least 2.
- NUM_BUSES, 2, number of CDB channels; must satisfy 1 ≤ NUM_BUSES ≤ NUM_REQ.
- DATA_W, 64, payload width per result (result value, tags, jump info, packed by the caller).
- SRC_W, $clog2(NUM_REQ), width of the source-index field.
- STARVE_LIMIT, 8, wait cycles before a requester is treated as starving; only used with the guard compiled in.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush (mispredict).
- req_valid  in  NUM_REQ  per-unit result pending.
- req_data  in  NUM_REQ*DATA_W  per-unit payload; unit i occupies bits [i*DATA_W +: DATA_W].
- req_grant  out  NUM_REQ  per-unit grant (combinational).
- cdb_valid  out  NUM_BUSES  bus k carries a result.
- cdb_data  out  NUM_BUSES*DATA_W  bus payloads.
- cdb_src  out  NUM_BUSES*SRC_W  index of the unit driving bus k.

## Operation
- Eligible set: req_valid & ~{NUM_REQ{flush|reset}}.
- Round-robin pointer rr_ptr (SRC_W bits) is reset to 0.
- Scan runs circularly from rr_ptr. The first NUM_BUSES eligible units win; the j-th winner in scan order is assigned bus j.
- Fewer winners than buses: the unused buses have cdb_valid=0, with data and src zero.
- req_grant[i]=1 exactly for winners. At most one grant per unit and one unit per bus.
- Pointer update:
  - At least one grant: rr_ptr ← (index of last winner + 1) mod NUM_REQ, which wraps from NUM_REQ-1 to 0.
  - No grants: rr_ptr is unchanged.
- Requester protocol: a unit holds req_valid and req_data stable until the cycle in which req_grant=1. It may present a new result in the following cycle.
- Flush: no grants are issued in that cycle and rr_ptr holds. Buses already registered in the flush cycle still broadcast, and consumers discard them.
- Reset: all outputs 0, rr_ptr=0, wait counters 0.

## Timing
- req_grant is combinational in cycle t, from req_valid, flush, reset and state.
- cdb_valid/data/src are registered and visible in cycle t+1 for exactly one cycle.
- Arbitration-to-broadcast latency is 1 cycle.
- Throughput is NUM_BUSES results per cycle.
- No combinational path from req_data to req_grant.
- Reset asserted mid-operation: the next edge clears all outputs, and pending grants from that cycle are suppressed.

## Configuration
- CDB_ARB_STARVE_GUARD_EN defined:
  - Each unit has a saturating counter wait_cnt[i] of width $clog2(STARVE_LIMIT+1).
  - The counter increments when the unit is eligible and not granted. It clears on a grant or when req_valid=0.
  - A unit with wait_cnt==STARVE_LIMIT is starving.
  - Starving units are granted first, in ascending index order, up to NUM_BUSES. Round-robin then fills the remaining buses, skipping units already granted.
  - rr_ptr updates only from the last round-robin-phase winner; if there were none, it holds.
  - Flush clears all counters.
- Not defined: pure round-robin as described in Operation; no counters are synthesised.

## Test plan
- NUM_REQ=5, NUM_BUSES=2, reset, then all req_valid=1 for 3 cycles, no grant consumption (units re-request):
  - grants {0,1}, then {2,3}, then {4,0}.
  - cdb_src on bus0/bus1 one cycle later: 0/1, 2/3, 4/0.
- Only unit 3 valid, req_data=0xDEAD:
  - req_grant=5'b01000.
  - Next cycle: cdb_valid=2'b01, cdb_data bus0=0xDEAD, cdb_src bus0=3, bus1 zero.
- Flush in the same cycle as req_valid=5'b11111: req_grant=0 and rr_ptr unchanged; the following cycle has cdb_valid=0.
- Reset asserted while buses are valid: the next cycle has cdb_valid=0 and rr_ptr=0. The first post-reset grant goes to units 0 and 1.
- No requests for 4 cycles, then req_valid=5'b10001 with rr_ptr=2: grants {4,0}, bus0=4, bus1=0, and rr_ptr becomes 1.
- Guard enabled, STARVE_LIMIT=2, NUM_BUSES=1:
  - Unit 1 is held valid while unit 0 re-requests, with rr_ptr forced toward unit 0 by prior traffic.
  - Once unit 1's wait_cnt reaches 2, it is granted in the next arbitration cycle regardless of rr_ptr.
  - Its counter then clears.
